// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per clock; result = {remainder, quotient}, with a sign fix-up at the end.
module div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 div_ready,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned LAST_STEP = WIDTH - 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_sdiv, w_sdiv_nxt;
    logic               r_sa, w_sa_nxt;
    logic               r_sb, w_sb_nxt;
    logic [WIDTH-1:0]   r_dvd, w_dvd_nxt;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic               w_busy_nxt;
    logic               w_ready_nxt;
    logic [2*WIDTH-1:0] w_result_nxt;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_q_fix, w_r_fix;

    // Partial remainder is shifted into WIDTH+1 bits so large unsigned divisors stay exact.
    assign w_abs_a  = (signed_div && a[WIDTH-1]) ? -a : a;
    assign w_abs_b  = (signed_div && b[WIDTH-1]) ? -b : b;
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_dvs;

    // A zero divisor leaves the raw dividend in r_dvd, which becomes the remainder.
    always_comb begin
        w_q_fix = r_dvd;
        w_r_fix = r_rem;
        if (r_dvs == '0) begin
            w_q_fix = '1;
            w_r_fix = r_dvd;
        end else if (r_sdiv) begin
            if (r_sa ^ r_sb) w_q_fix = -r_dvd;
            if (r_sa)        w_r_fix = -r_rem;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sdiv_nxt   = r_sdiv;
        w_sa_nxt     = r_sa;
        w_sb_nxt     = r_sb;
        w_dvd_nxt    = r_dvd;
        w_dvs_nxt    = r_dvs;
        w_rem_nxt    = r_rem;
        w_busy_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;
        w_result_nxt = result;
        case (r_state)
            S_IDLE: begin
                if (start && !annul) begin
                    w_sdiv_nxt  = signed_div;
                    w_sa_nxt    = a[WIDTH-1];
                    w_sb_nxt    = b[WIDTH-1];
                    w_dvd_nxt   = (b == '0) ? a : w_abs_a;
                    w_dvs_nxt   = w_abs_b;
                    w_rem_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (b == '0) ? S_FIX : S_BUSY;
                end
            end
            S_BUSY: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rem_nxt   = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                    w_dvd_nxt   = {r_dvd[WIDTH-2:0], w_ge};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_busy_nxt  = 1'b1;
                    if (r_cnt == CNT_W'(LAST_STEP)) w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                if (annul) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_result_nxt = {w_r_fix, w_q_fix};
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sdiv    <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            busy      <= 1'b0;
            div_ready <= 1'b0;
            result    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sdiv    <= w_sdiv_nxt;
            r_sa      <= w_sa_nxt;
            r_sb      <= w_sb_nxt;
            r_dvd     <= w_dvd_nxt;
            r_dvs     <= w_dvs_nxt;
            r_rem     <= w_rem_nxt;
            busy      <= w_busy_nxt;
            div_ready <= w_ready_nxt;
            result    <= w_result_nxt;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// divide by zero, annul, back-to-back operation and asynchronous reset.
module tb_div_unit;

    localparam int unsigned WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              signed_div;
    logic              annul;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              div_ready;
    logic              busy;
    logic [2*WIDTH-1:0] result;

    int checks;
    int errors;
    logic [63:0] last_result;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .div_ready  (div_ready),
        .busy       (busy),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge, let the next posedge (E0) sample them, then drop start.
    task automatic start_op(input logic sd, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] exp,
                           input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        start_op(sd, av, bv);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (div_ready) begin
                lat = cyc;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
        @(negedge clk);
        check({tag, " ready pulse"}, 64'(div_ready), 64'd0);
        last_result = exp;
    endtask

    initial begin
        int pulses;
        int first_cyc;
        int gap;
        logic [63:0] res1;
        logic [63:0] res2;

        checks      = 0;
        errors      = 0;
        rst         = 1'b0;
        start       = 1'b0;
        signed_div  = 1'b0;
        annul       = 1'b0;
        a           = '0;
        b           = '0;
        last_result = '0;

        #3;
        check("reset ready", 64'(div_ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 33);
        run_div("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 33);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 34, 33);
        run_div("div ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 34, 33);
        run_div("divu max/1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 34, 33);
        run_div("divu big dvs", 1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, 34, 33);
        run_div("div by zero", 1'b0, 32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 2, 1);

        // Annul after ten restoring steps.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        @(negedge clk);
        check("annul busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_ready) pulses++;
        end
        check("annul no ready", 64'(pulses), 64'd0);
        check("annul result held", result, last_result);
        run_div("after annul", 1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 34, 33);

        // annul wins over start while idle.
        @(negedge clk);
        start = 1'b1;
        annul = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        check("idle annul busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        // start held through the operation, then a back-to-back second divide.
        start      = 1'b1;
        signed_div = 1'b0;
        a          = 32'd9;
        b          = 32'd3;
        pulses     = 0;
        first_cyc  = 0;
        gap        = 0;
        res1       = '0;
        res2       = '0;
        for (int cyc = 1; cyc <= 110; cyc++) begin
            @(negedge clk);
            if (div_ready) begin
                pulses++;
                if (pulses == 1) begin
                    res1      = result;
                    first_cyc = cyc;
                    a         = 32'd20;
                    b         = 32'd6;
                end else if (pulses == 2) begin
                    res2  = result;
                    gap   = cyc - first_cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b pulses", 64'(pulses), 64'd2);
        check("b2b first", res1, {32'd0, 32'd3});
        check("b2b second", res2, {32'd2, 32'd3});
        check("b2b gap", 64'(gap), 64'd35);
        last_result = {32'd2, 32'd3};

        // Asynchronous reset in the middle of a divide.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async rst ready", 64'(div_ready), 64'd0);
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst busy", 64'(busy), 64'd0);
        check("post rst ready", 64'(div_ready), 64'd0);
        run_div("post rst div", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 34, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
